// File: rtl/store_buffer_forwarding.sv
// Store buffer: queues committed stores in a circular FIFO, drains them in program order
// over the storeValid/storeComplete handshake, and forwards pending bytes to younger loads.
module store_buffer_forwarding #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enqValid,
    output logic                       enqReady,
    input  logic [XLEN-1:0]            enqAddress,
    input  logic [XLEN-1:0]            enqData,
    input  logic [XLEN/8-1:0]          enqByteEnable,
    input  logic                       queryValid,
    input  logic [XLEN-1:0]            queryAddress,
    input  logic [XLEN/8-1:0]          queryByteEnable,
    output logic                       loadHit,
    output logic                       loadConflict,
    output logic [XLEN-1:0]            forwardData,
    output logic                       storeValid,
    output logic [XLEN-1:0]            storeAddress,
    output logic [XLEN-1:0]            storeData,
    output logic [XLEN/8-1:0]          storeByteEnable,
    input  logic                       storeComplete,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e state_q, state_d;

    // Entry storage; only the word address is kept since matching ignores the low two bits.
    logic [DEPTH-1:0] valid_q;
    logic [XLEN-3:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [LANES-1:0] be_q   [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic             store_valid_q;
    logic [XLEN-1:0]  store_addr_q;
    logic [XLEN-1:0]  store_data_q;
    logic [LANES-1:0] store_be_q;

    logic             full;
    logic             push;
    logic             pop;
    logic             issue_start;

    logic [LANES-1:0] covered;
    logic [XLEN-1:0]  fwd_bytes;
    logic [PTR_W-1:0] idx;

    logic             unused_low_bits;

    assign unused_low_bits = ^{enqAddress[1:0], queryAddress[1:0]};

    // No same-cycle pass-through: a pop does not free a slot for this cycle's enqueue.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign enqReady = !full;
    assign push     = enqValid && !full;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Drain FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state: start an issue whenever entries are pending, finish on completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StIssue;
            StIssue: if (storeComplete) state_d = StIdle;
        endcase
    end

    // Drain FSM outputs: latch the head on issue start, pop it when memory accepts.
    always_comb begin
        issue_start = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            StIdle:  issue_start = (count_q != '0);
            StIssue: pop = storeComplete;
        endcase
    end

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            // head == tail only when empty or full, so push and pop never hit the same slot.
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
        end
    end

    // Entry payload write; gated by valid bits so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q] <= enqAddress[XLEN-1:2];
            data_q[tail_q] <= enqData;
            be_q[tail_q]   <= enqByteEnable;
        end
    end

    // Memory-side request registers, held stable for the whole handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            store_valid_q <= 1'b0;
            store_addr_q  <= '0;
            store_data_q  <= '0;
            store_be_q    <= '0;
        end else if (issue_start) begin
            store_valid_q <= 1'b1;
            store_addr_q  <= {addr_q[head_q], 2'b00};
            store_data_q  <= data_q[head_q];
            store_be_q    <= be_q[head_q];
        end else if (pop) begin
            store_valid_q <= 1'b0;
        end
    end

    // Byte-wise forwarding: walk oldest to youngest so younger matches overwrite older ones.
    always_comb begin
        covered   = '0;
        fwd_bytes = '0;
        idx       = head_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == queryAddress[XLEN-1:2])) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    if (be_q[idx][l] && queryByteEnable[l]) begin
                        covered[l]         = 1'b1;
                        fwd_bytes[l*8 +: 8] = data_q[idx][l*8 +: 8];
                    end
                end
            end
        end
    end

    assign loadHit      = queryValid && (covered == queryByteEnable) && (queryByteEnable != '0);
    assign loadConflict = queryValid && (covered != '0) && !loadHit;
    assign forwardData  = loadHit ? fwd_bytes : '0;

    assign storeValid      = store_valid_q;
    assign storeAddress    = store_addr_q;
    assign storeData       = store_data_q;
    assign storeByteEnable = store_be_q;
    assign empty           = (count_q == '0);
    assign count           = count_q;

endmodule

// File: tb/tb_store_buffer_forwarding.sv
// Self-checking bench for store_buffer_forwarding: directed scenarios plus a randomized run
// against a queue-based transaction model of the buffer.
module tb_store_buffer_forwarding;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        enqValid;
    logic        enqReady;
    logic [31:0] enqAddress;
    logic [31:0] enqData;
    logic [3:0]  enqByteEnable;
    logic        queryValid;
    logic [31:0] queryAddress;
    logic [3:0]  queryByteEnable;
    logic        loadHit;
    logic        loadConflict;
    logic [31:0] forwardData;
    logic        storeValid;
    logic [31:0] storeAddress;
    logic [31:0] storeData;
    logic [3:0]  storeByteEnable;
    logic        storeComplete;
    logic        empty;
    logic [2:0]  count;

    store_buffer_forwarding #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .enqValid        (enqValid),
        .enqReady        (enqReady),
        .enqAddress      (enqAddress),
        .enqData         (enqData),
        .enqByteEnable   (enqByteEnable),
        .queryValid      (queryValid),
        .queryAddress    (queryAddress),
        .queryByteEnable (queryByteEnable),
        .loadHit         (loadHit),
        .loadConflict    (loadConflict),
        .forwardData     (forwardData),
        .storeValid      (storeValid),
        .storeAddress    (storeAddress),
        .storeData       (storeData),
        .storeByteEnable (storeByteEnable),
        .storeComplete   (storeComplete),
        .empty           (empty),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;

    // Model: pending stores in program order; front is the one memory sees next.
    st_t q[$];
    bit  m_issuing;
    int  total = 0;
    int  bad   = 0;

    task automatic set_enq(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        enqValid      = v;
        enqAddress    = a;
        enqData       = d;
        enqByteEnable = be;
    endtask

    // Advance one clock and apply the same transition to the model, return at negedge.
    task automatic tick();
        bit  acc, pop, start;
        st_t e;
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_issuing = 0;
        end else begin
            acc   = enqValid && (q.size() < DEPTH);
            pop   = m_issuing && storeComplete;
            start = !m_issuing && (q.size() != 0);
            if (pop) begin
                void'(q.pop_front());
                m_issuing = 0;
            end
            if (start) m_issuing = 1;
            if (acc) begin
                e.addr = enqAddress;
                e.data = enqData;
                e.be   = enqByteEnable;
                q.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    // Reference forwarding: youngest pending store wins each requested byte.
    function automatic void ref_query(input logic qv, input logic [31:0] a, input logic [3:0] be,
                                      output logic hit, output logic conf,
                                      output logic [31:0] d);
        logic [3:0]  cov = '0;
        logic [31:0] m   = '0;
        foreach (q[i]) begin
            if (q[i].addr[31:2] == a[31:2]) begin
                for (int l = 0; l < 4; l++) begin
                    if (be[l] && q[i].be[l]) begin
                        cov[l]      = 1'b1;
                        m[l*8 +: 8] = q[i].data[l*8 +: 8];
                    end
                end
            end
        end
        hit  = qv && (cov == be) && (be != 4'b0);
        conf = qv && (cov != 4'b0) && !hit;
        d    = hit ? m : 32'h0;
    endfunction

    // Complete every pending store, checking each issued request against the model front.
    task automatic drain_all(input string tag);
        int cyc = 0;
        storeComplete = 1'b0;
        while ((q.size() != 0 || m_issuing) && cyc < 200) begin
            total++;
            if (storeValid !== m_issuing) begin
                bad++;
                $display("FAIL %s drain storeValid got=%0b want=%0b", tag, storeValid, m_issuing);
            end
            if (m_issuing) begin
                total++;
                if (storeAddress !== {q[0].addr[31:2], 2'b00} || storeData !== q[0].data ||
                    storeByteEnable !== q[0].be) begin
                    bad++;
                    $display("FAIL %s drain order got=%h/%h/%b want=%h/%h/%b", tag,
                             storeAddress, storeData, storeByteEnable,
                             {q[0].addr[31:2], 2'b00}, q[0].data, q[0].be);
                end
            end
            storeComplete = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        storeComplete = 1'b0;
        total++;
        if (cyc >= 200 || count !== 3'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL %s drain_end cycles=%0d count=%0d empty=%0b want count=0 empty=1",
                     tag, cyc, count, empty);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || enqReady !== 1'b1 || storeValid !== 1'b0 ||
            storeAddress !== 32'h0 || storeData !== 32'h0 || storeByteEnable !== 4'h0) begin
            bad++;
            $display("FAIL reset_state count=%0d empty=%0b rdy=%0b sv=%0b sa=%h sd=%h sbe=%b want 0/1/1/0/0/0/0",
                     count, empty, enqReady, storeValid, storeAddress, storeData, storeByteEnable);
        end
    endtask

    task automatic test_single_store();
        set_enq(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        total++;
        if (storeValid !== 1'b0 || count !== 3'd1) begin
            bad++;
            $display("FAIL single_enq sv=%0b count=%0d want 0/1", storeValid, count);
        end
        tick();
        total++;
        if (storeValid !== 1'b1 || storeAddress !== 32'h100 || storeData !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_issue sv=%0b sa=%h sd=%h want 1/100/deadbeef",
                     storeValid, storeAddress, storeData);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (storeValid !== 1'b1 || storeAddress !== 32'h100 || count !== 3'd1) begin
                bad++;
                $display("FAIL single_hold sv=%0b sa=%h count=%0d want 1/100/1",
                         storeValid, storeAddress, count);
            end
        end
        storeComplete = 1'b1;
        tick();
        storeComplete = 1'b0;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || storeValid !== 1'b0) begin
            bad++;
            $display("FAIL single_done count=%0d empty=%0b sv=%0b want 0/1/0",
                     count, empty, storeValid);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
            tick();
        end
        set_enq(1'b1, 32'h110, 32'hBAD, 4'hF);
        total++;
        if (count !== 3'd4 || enqReady !== 1'b0) begin
            bad++;
            $display("FAIL full_count count=%0d rdy=%0b want 4/0", count, enqReady);
        end
        tick();
        total++;
        if (count !== 3'd4 || storeAddress !== 32'h100 || storeValid !== 1'b1) begin
            bad++;
            $display("FAIL full_reject count=%0d sa=%h sv=%0b want 4/100/1",
                     count, storeAddress, storeValid);
        end
        storeComplete = 1'b1;
        #1;
        total++;
        if (enqReady !== 1'b0) begin
            bad++;
            $display("FAIL full_no_passthru rdy=%0b want 0", enqReady);
        end
        tick();
        storeComplete = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        total++;
        if (count !== 3'd3 || enqReady !== 1'b1) begin
            bad++;
            $display("FAIL full_after_pop count=%0d rdy=%0b want 3/1", count, enqReady);
        end
        drain_all("full");
    endtask

    task automatic test_byte_merge();
        set_enq(1'b1, 32'h200, 32'h11223344, 4'b1111);
        tick();
        set_enq(1'b1, 32'h201, 32'h0000AA00, 4'b0010);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        queryValid      = 1'b1;
        queryAddress    = 32'h200;
        queryByteEnable = 4'b1111;
        #1;
        total++;
        if (loadHit !== 1'b1 || loadConflict !== 1'b0 || forwardData !== 32'h1122AA44) begin
            bad++;
            $display("FAIL merge_lw hit=%0b conf=%0b data=%h want 1/0/1122aa44",
                     loadHit, loadConflict, forwardData);
        end
        queryValid = 1'b0;
        #1;
        total++;
        if (loadHit !== 1'b0 || loadConflict !== 1'b0 || forwardData !== 32'h0) begin
            bad++;
            $display("FAIL merge_novalid hit=%0b conf=%0b data=%h want 0/0/0",
                     loadHit, loadConflict, forwardData);
        end
        drain_all("merge");
    endtask

    task automatic test_conflict();
        set_enq(1'b1, 32'h302, 32'h00550000, 4'b0100);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        queryValid      = 1'b1;
        queryAddress    = 32'h300;
        queryByteEnable = 4'b1111;
        #1;
        total++;
        if (loadHit !== 1'b0 || loadConflict !== 1'b1 || forwardData !== 32'h0) begin
            bad++;
            $display("FAIL conflict_lw hit=%0b conf=%0b data=%h want 0/1/0",
                     loadHit, loadConflict, forwardData);
        end
        queryAddress    = 32'h301;
        queryByteEnable = 4'b0010;
        #1;
        total++;
        if (loadHit !== 1'b0 || loadConflict !== 1'b0) begin
            bad++;
            $display("FAIL conflict_lb hit=%0b conf=%0b want 0/0", loadHit, loadConflict);
        end
        queryValid = 1'b0;
        drain_all("conflict");
    endtask

    task automatic test_back_to_back();
        int enqs = 0;
        int cyc  = 0;
        set_enq(1'b1, 32'h600, 32'h600, 4'hF);
        tick();
        set_enq(1'b1, 32'h604, 32'h604, 4'hF);
        tick();
        while (enqs < 10 && cyc < 60) begin
            if (storeValid) begin
                total++;
                if (storeAddress !== {q[0].addr[31:2], 2'b00} || storeData !== q[0].data) begin
                    bad++;
                    $display("FAIL b2b_order got=%h/%h want=%h/%h", storeAddress, storeData,
                             {q[0].addr[31:2], 2'b00}, q[0].data);
                end
                set_enq(1'b1, 32'h700 + 32'(enqs * 4), 32'hC000 + 32'(enqs), 4'hF);
                storeComplete = 1'b1;
                enqs++;
            end else begin
                set_enq(1'b0, 32'h0, 32'h0, 4'h0);
                storeComplete = 1'b0;
            end
            tick();
            cyc++;
            total++;
            if (count !== 3'd2) begin
                bad++;
                $display("FAIL b2b_count count=%0d want 2", count);
            end
        end
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        storeComplete = 1'b0;
        total++;
        if (enqs != 10) begin
            bad++;
            $display("FAIL b2b_budget enqueued=%0d want 10", enqs);
        end
        drain_all("b2b");
    endtask

    task automatic test_random();
        logic        h, c;
        logic [31:0] d;
        for (int n = 0; n < 400; n++) begin
            queryValid      = 1'($urandom_range(0, 3) != 0);
            queryAddress    = 32'h400 + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3));
            queryByteEnable = 4'($urandom_range(0, 15));
            #1;
            ref_query(queryValid, queryAddress, queryByteEnable, h, c, d);
            total++;
            if (loadHit !== h || loadConflict !== c || forwardData !== d) begin
                bad++;
                $display("FAIL rand_fwd a=%h be=%b got=%0b/%0b/%h want=%0b/%0b/%h",
                         queryAddress, queryByteEnable, loadHit, loadConflict, forwardData,
                         h, c, d);
            end
            total++;
            if (count !== 3'(q.size()) || enqReady !== (q.size() < DEPTH) ||
                storeValid !== m_issuing) begin
                bad++;
                $display("FAIL rand_state count=%0d rdy=%0b sv=%0b want %0d/%0b/%0b",
                         count, enqReady, storeValid, q.size(), q.size() < DEPTH, m_issuing);
            end
            if (m_issuing) begin
                total++;
                if (storeAddress !== {q[0].addr[31:2], 2'b00} || storeData !== q[0].data ||
                    storeByteEnable !== q[0].be) begin
                    bad++;
                    $display("FAIL rand_issue got=%h/%h/%b want=%h/%h/%b",
                             storeAddress, storeData, storeByteEnable,
                             {q[0].addr[31:2], 2'b00}, q[0].data, q[0].be);
                end
            end
            set_enq(1'($urandom_range(0, 1)),
                    32'h400 + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)));
            storeComplete = 1'($urandom_range(0, 2) == 0);
            tick();
        end
        queryValid = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        drain_all("rand");
    endtask

    task automatic test_reset_mid_issue();
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, 32'h500 + 32'(i * 4), 32'h5000 + 32'(i), 4'hF);
            tick();
        end
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        total++;
        if (storeValid !== 1'b1 || count !== 3'd3) begin
            bad++;
            $display("FAIL rst_mid_pre sv=%0b count=%0d want 1/3", storeValid, count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        queryValid      = 1'b1;
        queryAddress    = 32'h500;
        queryByteEnable = 4'hF;
        #1;
        total++;
        if (storeValid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 ||
            loadHit !== 1'b0 || loadConflict !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_post sv=%0b count=%0d empty=%0b hit=%0b conf=%0b want 0/0/1/0/0",
                     storeValid, count, empty, loadHit, loadConflict);
        end
        queryValid = 1'b0;
        tick();
        total++;
        if (storeValid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_idle sv=%0b want 0", storeValid);
        end
    endtask

    initial begin
        m_issuing       = 0;
        reset           = 1'b1;
        storeComplete   = 1'b0;
        queryValid      = 1'b0;
        queryAddress    = 32'h0;
        queryByteEnable = 4'h0;
        set_enq(1'b0, 32'h0, 32'h0, 4'h0);
        test_reset();
        test_single_store();
        test_full();
        test_byte_merge();
        test_conflict();
        test_back_to_back();
        test_random();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
